// File: rtl/pipelined_execute_unit.sv
// Single-issue execute unit: 1-cycle RV32I ALU/branch ops, a multi-cycle multiplier and a
// restoring divider, one result at a time held on the common data bus until granted.
module pipelined_execute_unit #(
    parameter int WORD_WIDTH  = 32,
    parameter int TAG_WIDTH   = 4,
    parameter int OP_WIDTH    = 6,
    parameter int MUL_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,
    input  logic                  rs_calculate_signal_in,
    input  logic [OP_WIDTH-1:0]   rs_op_in,
    input  logic [WORD_WIDTH-1:0] rs_imm_in,
    input  logic [WORD_WIDTH-1:0] rs_pc_in,
    input  logic [WORD_WIDTH-1:0] rs_rs1val_in,
    input  logic [WORD_WIDTH-1:0] rs_rs2val_in,
    input  logic [TAG_WIDTH-1:0]  rs_dest_in,
    output logic                  busy_out,
    output logic                  broadcast_signal_out,
    input  logic                  cdb_grant_in,
    output logic [WORD_WIDTH-1:0] result_out,
    output logic [TAG_WIDTH-1:0]  dest_tag_out,
    output logic [WORD_WIDTH-1:0] rob_new_pc_out
);
    localparam int W       = WORD_WIDTH;
    localparam int SH_W    = $clog2(WORD_WIDTH);
    localparam int CNT_MAX = (WORD_WIDTH > MUL_LATENCY) ? WORD_WIDTH : MUL_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [OP_WIDTH-1:0] OP_LUI    = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_AUIPC  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_JAL    = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_JALR   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_BEQ    = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_BNE    = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_BLT    = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_BGE    = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_BLTU   = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_BGEU   = OP_WIDTH'(10);
    localparam logic [OP_WIDTH-1:0] OP_ADDI   = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] OP_SLTI   = OP_WIDTH'(12);
    localparam logic [OP_WIDTH-1:0] OP_SLTIU  = OP_WIDTH'(13);
    localparam logic [OP_WIDTH-1:0] OP_XORI   = OP_WIDTH'(14);
    localparam logic [OP_WIDTH-1:0] OP_ORI    = OP_WIDTH'(15);
    localparam logic [OP_WIDTH-1:0] OP_ANDI   = OP_WIDTH'(16);
    localparam logic [OP_WIDTH-1:0] OP_SLLI   = OP_WIDTH'(17);
    localparam logic [OP_WIDTH-1:0] OP_SRLI   = OP_WIDTH'(18);
    localparam logic [OP_WIDTH-1:0] OP_SRAI   = OP_WIDTH'(19);
    localparam logic [OP_WIDTH-1:0] OP_ADD    = OP_WIDTH'(20);
    localparam logic [OP_WIDTH-1:0] OP_SUB    = OP_WIDTH'(21);
    localparam logic [OP_WIDTH-1:0] OP_SLL    = OP_WIDTH'(22);
    localparam logic [OP_WIDTH-1:0] OP_SLT    = OP_WIDTH'(23);
    localparam logic [OP_WIDTH-1:0] OP_SLTU   = OP_WIDTH'(24);
    localparam logic [OP_WIDTH-1:0] OP_XOR    = OP_WIDTH'(25);
    localparam logic [OP_WIDTH-1:0] OP_SRL    = OP_WIDTH'(26);
    localparam logic [OP_WIDTH-1:0] OP_SRA    = OP_WIDTH'(27);
    localparam logic [OP_WIDTH-1:0] OP_OR     = OP_WIDTH'(28);
    localparam logic [OP_WIDTH-1:0] OP_AND    = OP_WIDTH'(29);
    localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(30);
    localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(31);
    localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(32);
    localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(33);
    localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(34);
    localparam logic [OP_WIDTH-1:0] OP_DIVU   = OP_WIDTH'(35);
    localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(36);
    localparam logic [OP_WIDTH-1:0] OP_REMU   = OP_WIDTH'(37);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]        result_q, result_d;
    logic [TAG_WIDTH-1:0] dest_q, dest_d;
    logic [W-1:0]        npc_q, npc_d;
    logic [OP_WIDTH-1:0] op_q, op_d;
    logic [W-1:0]        a_q, a_d;      // multiplicand, or dividend/quotient shift register
    logic [W-1:0]        b_q, b_d;      // multiplier, or divisor magnitude
    logic [W-1:0]        rem_q, rem_d;
    logic                negq_q, negq_d;
    logic                negr_q, negr_d;

    // single-cycle ALU / branch / jump path, evaluated on the issue operands
    logic [W-1:0]    rs1, rs2, imm, pc, pc4, pc_imm, jalr_t, alu_res, alu_npc;
    logic [SH_W-1:0] sh_i, sh_r;
    logic            take;

    always_comb begin
        rs1    = rs_rs1val_in;
        rs2    = rs_rs2val_in;
        imm    = rs_imm_in;
        pc     = rs_pc_in;
        pc4    = pc + W'(4);
        pc_imm = pc + imm;
        jalr_t = rs1 + imm;
        sh_i   = imm[SH_W-1:0];
        sh_r   = rs2[SH_W-1:0];
        take   = 1'b0;
        case (rs_op_in)
            OP_BEQ:  take = (rs1 == rs2);
            OP_BNE:  take = (rs1 != rs2);
            OP_BLT:  take = ($signed(rs1) < $signed(rs2));
            OP_BGE:  take = ($signed(rs1) >= $signed(rs2));
            OP_BLTU: take = (rs1 < rs2);
            OP_BGEU: take = (rs1 >= rs2);
            default: take = 1'b0;
        endcase
        alu_res = '0;
        alu_npc = pc4;
        case (rs_op_in)
            OP_LUI:   alu_res = imm;
            OP_AUIPC: begin alu_res = pc_imm; alu_npc = pc_imm; end
            OP_JAL:   begin alu_res = pc4; alu_npc = pc_imm; end
            OP_JALR:  begin alu_res = pc4; alu_npc = {jalr_t[W-1:1], 1'b0}; end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                alu_res = W'(take);
                alu_npc = take ? pc_imm : pc4;
            end
            OP_ADDI:  alu_res = rs1 + imm;
            OP_SLTI:  alu_res = W'($signed(rs1) < $signed(imm));
            OP_SLTIU: alu_res = W'(rs1 < imm);
            OP_XORI:  alu_res = rs1 ^ imm;
            OP_ORI:   alu_res = rs1 | imm;
            OP_ANDI:  alu_res = rs1 & imm;
            OP_SLLI:  alu_res = rs1 << sh_i;
            OP_SRLI:  alu_res = rs1 >> sh_i;
            OP_SRAI:  alu_res = $signed(rs1) >>> sh_i;
            OP_ADD:   alu_res = rs1 + rs2;
            OP_SUB:   alu_res = rs1 - rs2;
            OP_SLL:   alu_res = rs1 << sh_r;
            OP_SLT:   alu_res = W'($signed(rs1) < $signed(rs2));
            OP_SLTU:  alu_res = W'(rs1 < rs2);
            OP_XOR:   alu_res = rs1 ^ rs2;
            OP_SRL:   alu_res = rs1 >> sh_r;
            OP_SRA:   alu_res = $signed(rs1) >>> sh_r;
            OP_OR:    alu_res = rs1 | rs2;
            OP_AND:   alu_res = rs1 & rs2;
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_res = '0;
            default:  alu_npc = pc;
        endcase
    end

    // one multiplier shared by the latency-1 issue path and the MUL state
    logic [OP_WIDTH-1:0] mul_op;
    logic [W-1:0]        mul_a, mul_b, mul_res;
    logic                mul_a_sgn, mul_b_sgn;
    logic [2*W-1:0]      prod;

    always_comb begin
        mul_op    = (state_q == S_IDLE) ? rs_op_in : op_q;
        mul_a     = (state_q == S_IDLE) ? rs1 : a_q;
        mul_b     = (state_q == S_IDLE) ? rs2 : b_q;
        mul_a_sgn = ((mul_op == OP_MULH) || (mul_op == OP_MULHSU)) && mul_a[W-1];
        mul_b_sgn = (mul_op == OP_MULH) && mul_b[W-1];
        prod      = {{W{mul_a_sgn}}, mul_a} * {{W{mul_b_sgn}}, mul_b};
        mul_res   = (mul_op == OP_MUL) ? prod[W-1:0] : prod[2*W-1:W];
    end

    // one restoring-division step on the unsigned magnitudes
    logic [W:0]   rem_sh, diff;
    logic         ge;
    logic [W-1:0] nxt_quo, nxt_rem, fin_q, fin_r;

    always_comb begin
        rem_sh  = {rem_q, a_q[W-1]};
        diff    = rem_sh - {1'b0, b_q};
        ge      = ~diff[W];
        nxt_quo = {a_q[W-2:0], ge};
        nxt_rem = ge ? diff[W-1:0] : rem_sh[W-1:0];
        fin_q   = negq_q ? -nxt_quo : nxt_quo;
        fin_r   = negr_q ? -nxt_rem : nxt_rem;
    end

    logic is_mul, is_div, div_sgn, div_rem;

    always_comb begin
        is_mul  = (rs_op_in == OP_MUL) || (rs_op_in == OP_MULH) ||
                  (rs_op_in == OP_MULHSU) || (rs_op_in == OP_MULHU);
        is_div  = (rs_op_in == OP_DIV) || (rs_op_in == OP_DIVU) ||
                  (rs_op_in == OP_REM) || (rs_op_in == OP_REMU);
        div_sgn = (rs_op_in == OP_DIV) || (rs_op_in == OP_REM);
        div_rem = (rs_op_in == OP_REM) || (rs_op_in == OP_REMU);

        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dest_d   = dest_q;
        npc_d    = npc_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        negq_d   = negq_q;
        negr_d   = negr_q;

        if (rdy_in) begin
            if (clear_in) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    S_IDLE: if (rs_calculate_signal_in) begin
                        dest_d = rs_dest_in;
                        op_d   = rs_op_in;
                        npc_d  = alu_npc;
                        cnt_d  = '0;
                        a_d    = rs1;
                        b_d    = rs2;
                        if (is_mul) begin
                            if (MUL_LATENCY == 1) begin
                                result_d = mul_res;
                                state_d  = S_DONE;
                            end else begin
                                state_d = S_MUL;
                            end
                        end else if (is_div) begin
                            if (rs2 == '0) begin
                                result_d = div_rem ? rs1 : '1;
                                state_d  = S_DONE;
                            end else if (div_sgn && rs1 == {1'b1, {(W-1){1'b0}}} && rs2 == '1) begin
                                result_d = div_rem ? '0 : rs1;
                                state_d  = S_DONE;
                            end else begin
                                a_d     = (div_sgn && rs1[W-1]) ? -rs1 : rs1;
                                b_d     = (div_sgn && rs2[W-1]) ? -rs2 : rs2;
                                rem_d   = '0;
                                negq_d  = div_sgn && (rs1[W-1] ^ rs2[W-1]);
                                negr_d  = div_sgn && rs1[W-1];
                                state_d = S_DIV;
                            end
                        end else begin
                            result_d = alu_res;
                            state_d  = S_DONE;
                        end
                    end
                    S_MUL: begin
                        if (cnt_q == CNT_W'(MUL_LATENCY - 2)) begin
                            result_d = mul_res;
                            state_d  = S_DONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    S_DIV: begin
                        a_d   = nxt_quo;
                        rem_d = nxt_rem;
                        if (cnt_q == CNT_W'(W - 1)) begin
                            result_d = ((op_q == OP_REM) || (op_q == OP_REMU)) ? fin_r : fin_q;
                            state_d  = S_DONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: if (cdb_grant_in) state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            dest_q   <= '0;
            npc_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dest_q   <= dest_d;
            npc_q    <= npc_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
        end
    end

    assign busy_out             = (state_q != S_IDLE);
    assign broadcast_signal_out = (state_q == S_DONE);
    assign result_out           = result_q;
    assign dest_tag_out         = dest_q;
    assign rob_new_pc_out       = npc_q;

endmodule
